// File: rtl/iic_pkg.sv
// Shared FSM state encoding and protocol constants for the IIC configuration sequencer.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_RDY,
        ISSUE,
        ACK,
        XFER,
        DRAIN,
        GAP,
        FINISH
    } iic_state_t;

    localparam int          IIC_CFG_BYTES = 3;
    localparam logic [15:0] IIC_TBL_END   = 16'hFFFF;

endpackage

// File: rtl/iic_wait_cnt.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module iic_wait_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/iic_cfg_seq.sv
// IIC register-configuration sequencer: one 3-byte write (dev, reg, data) per table entry.
// Optional transfer watchdog enabled by defining IIC_CFG_TIMEOUT_EN.
module iic_cfg_seq
    import iic_pkg::*;
#(
    parameter int         NUM_REGS       = 16,
    parameter logic [7:0] DEV_ADDR       = 8'h78,
    parameter int         GAP_CYCLES     = 64,
    parameter int         TIMEOUT_CYCLES = 4096,
    localparam int        IW             = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [IW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    output logic [7:0]    send_bytes,
    output logic          m_tvalid,
    output logic [7:0]    m_tdata,
    input  logic          m_tready
);

    // Counter widths hold the reload value N-1, which is why N>=2 is required.
    localparam int GW = $clog2(GAP_CYCLES);

    iic_state_t    state_q;
    logic [IW-1:0] idx_q;
    logic          busy_q;
    logic          done_q;
    logic          tvalid_q;
    logic [7:0]    tdata_q;
    logic          fetch_ph_q;
    logic [1:0]    byte_idx_q;
    logic          drain_hi_q;
    logic          rdy_q;
    logic [15:0]   ent_q;
    logic          gap_zero;

    iic_wait_cnt #(.W(GW)) u_gap_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (state_q == DRAIN),
        .val_i  (GW'(GAP_CYCLES - 1)),
        .dec_i  (state_q == GAP),
        .zero_o (gap_zero)
    );

`ifdef IIC_CFG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    iic_state_t prev_q;
    logic       err_q;
    logic       wd_watch;
    logic       wd_load;
    logic       wd_zero;
    logic       wd_fire;

    // Any state change (or leaving the watched states) rearms the watchdog.
    assign wd_watch = (state_q == WAIT_RDY) || (state_q == ACK) ||
                      (state_q == XFER)     || (state_q == DRAIN);
    assign wd_load  = !wd_watch || (state_q != prev_q);
    assign wd_fire  = wd_watch && !wd_load && wd_zero;

    iic_wait_cnt #(.W(TW)) u_wd_cnt (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (wd_load),
        .val_i  (TW'(TIMEOUT_CYCLES - 1)),
        .dec_i  (1'b1),
        .zero_o (wd_zero)
    );

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (state_q == FETCH && fetch_ph_q) begin
            ent_q <= tbl_data;
        end
    end

    always_ff @(posedge clk) begin
        rdy_q <= m_tready;
`ifdef IIC_CFG_TIMEOUT_EN
        prev_q <= state_q;
`endif
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tvalid_q   <= 1'b0;
            tdata_q    <= 8'h00;
            fetch_ph_q <= 1'b0;
            byte_idx_q <= 2'd0;
            drain_hi_q <= 1'b0;
`ifdef IIC_CFG_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        idx_q      <= '0;
                        fetch_ph_q <= 1'b0;
`ifdef IIC_CFG_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    fetch_ph_q <= ~fetch_ph_q;
                    if (fetch_ph_q) begin
                        state_q <= (tbl_data == IIC_TBL_END) ? FINISH : WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (m_tready) state_q <= ISSUE;
                end
                ISSUE: begin
                    tvalid_q   <= 1'b1;
                    tdata_q    <= DEV_ADDR;
                    byte_idx_q <= 2'd0;
                    state_q    <= ACK;
                end
                ACK: begin
                    if (!m_tready) state_q <= XFER;
                end
                XFER: begin
                    // Engine requests the next byte with a rising edge on m_tready.
                    if (m_tready && !rdy_q) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'(IIC_CFG_BYTES - 2)) begin
                            tdata_q    <= ent_q[7:0];
                            drain_hi_q <= 1'b0;
                            state_q    <= DRAIN;
                        end else begin
                            tdata_q <= ent_q[15:8];
                        end
                    end
                end
                DRAIN: begin
                    if (m_tready) begin
                        drain_hi_q <= 1'b1;
                        if (drain_hi_q) begin
                            tvalid_q <= 1'b0;
                            state_q  <= GAP;
                        end
                    end else begin
                        drain_hi_q <= 1'b0;
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        if (idx_q == IW'(NUM_REGS - 1)) begin
                            state_q <= FINISH;
                        end else begin
                            idx_q      <= idx_q + IW'(1);
                            fetch_ph_q <= 1'b0;
                            state_q    <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    tvalid_q <= 1'b0;
                    tdata_q  <= 8'h00;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef IIC_CFG_TIMEOUT_EN
            if (wd_fire) begin
                err_q    <= 1'b1;
                tvalid_q <= 1'b0;
                state_q  <= FINISH;
            end
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign tbl_addr   = idx_q;
    assign send_bytes = 8'(IIC_CFG_BYTES);
    assign m_tvalid   = tvalid_q;
    assign m_tdata    = tdata_q;

endmodule
